key_event_scheduler: RTL and testbench

Collects single-cycle press pulses from the per-key debounce/shaper instances of a DE-series board and turns them into one ordered event stream. Simultaneous presses are arbitrated round-robin so no key starves. Granted key indices go into a small FIFO read by the application FSM through a valid/ready handshake. The block sits between the key shapers and the application control logic.

---
 rtl/key_evt_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/key_event_scheduler.sv | 135 +++++++++++++
 tb/tb_key_event_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared constants and types for the key event scheduler.
package key_evt_pkg;

    // Default geometry: four keys feeding a four-entry event queue.
    localparam int N_KEYS_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CODE_W_DEF     = 2;

    // Pointer width for the default queue; the count needs one extra bit
    // so that a full queue is distinguishable from an empty one.
    localparam int PTR_W_DEF = $clog2(FIFO_DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    // Key index as carried through the event stream.
    typedef logic [CODE_W_DEF-1:0] key_code_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks one requesting key, searching from the key
// after the previous winner so every key gets a turn.
module rr_arbiter
    import key_evt_pkg::*;
#(
    parameter int N_KEYS = N_KEYS_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [N_KEYS-1:0] req,
    input  logic [CODE_W-1:0] last_grant,
    output logic              gnt_valid,
    output logic [CODE_W-1:0] gnt_idx
);

    // Walk offsets 1..N_KEYS from the last winner; the first requester seen wins.
    always_comb begin
        int          idx;
        logic [CODE_W-1:0] idx_c;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            idx   = (int'(last_grant) + k) % N_KEYS;
            idx_c = CODE_W'(idx);
            if (!gnt_valid && req[idx_c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_c;
            end
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Key event scheduler: latches per-key press pulses, arbitrates them
// round-robin and queues the winning key indices for the application FSM.
module key_event_scheduler
    import key_evt_pkg::*;
#(
    parameter int N_KEYS     = N_KEYS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CODE_W     = CODE_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_KEYS-1:0]           key_pulse,
    input  logic                        evt_ready,
    input  logic                        clr_overflow,
    output logic                        evt_valid,
    output logic [CODE_W-1:0]           evt_code,
    output logic [N_KEYS-1:0]           pending,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Registered state.
    logic [N_KEYS-1:0] pending_q;
    logic [CODE_W-1:0] last_grant_q;
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    // Next-state and control signals.
    logic              has_room;
    logic [N_KEYS-1:0] arb_req;
    logic              gnt_valid;
    logic [CODE_W-1:0] gnt_idx;
    logic [N_KEYS-1:0] gnt_onehot;
    logic [N_KEYS-1:0] drop_vec;
    logic              ovf_set;
    logic              push;
    logic              pop;
    logic [N_KEYS-1:0] pending_d;
    logic [CNT_W-1:0]  count_d;

    // Room is judged on the registered count, so a full queue never takes a
    // push even if the consumer pops in the same cycle.
    assign has_room = (count_q < CNT_W'(FIFO_DEPTH));
    assign arb_req  = pending_q & {N_KEYS{has_room}};

    rr_arbiter #(
        .N_KEYS (N_KEYS),
        .CODE_W (CODE_W)
    ) u_arb (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Decode the winner and work out which presses survive this cycle.
    always_comb begin
        gnt_onehot = '0;
        if (gnt_valid) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
        // A pulse on a key that is still waiting (and not leaving now) is lost.
        drop_vec  = key_pulse & pending_q & ~gnt_onehot;
        ovf_set   = |drop_vec;
        // A pulse in the grant cycle re-arms the key, keeping a second event.
        pending_d = (pending_q & ~gnt_onehot) | key_pulse;
    end

    assign push = gnt_valid;
    assign pop  = evt_valid && evt_ready;

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pending latches, arbitration history, pointers, count and overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= '0;
            last_grant_q <= CODE_W'(N_KEYS - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge values of the others.
            pending_q <= pending_d;
            count_q   <= count_d;
            if (gnt_valid) begin
                last_grant_q <= gnt_idx;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Event storage written at the tail on each grant.
    // NOTE: the storage array has no reset; stale entries are never visible
    // because the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= gnt_idx;
        end
    end

    // Outputs decoded from registers only.
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? mem[rd_ptr_q] : '0;
    assign pending    = pending_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed, table-driven bench for key_event_scheduler (default geometry).
module tb_key_event_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_pulse;
    logic       evt_ready;
    logic       clr_overflow;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [3:0] pending;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit         rst;
        logic [3:0] kp;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] ec;
        logic [3:0] ep;
        logic [2:0] cnt;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    key_event_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_pulse    (key_pulse),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .pending      (pending),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [1:0] ec,
                             input logic [3:0] ep, input logic [2:0] cnt, input logic ov);
        check({tag, ".valid"},    32'(evt_valid),  32'(ev));
        check({tag, ".code"},     32'(evt_code),   32'(ec));
        check({tag, ".pending"},  32'(pending),    32'(ep));
        check({tag, ".count"},    32'(fifo_count), 32'(cnt));
        check({tag, ".overflow"}, 32'(overflow),   32'(ov));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] kp, input logic rdy, input logic clr);
        key_pulse    = kp;
        evt_ready    = rdy;
        clr_overflow = clr;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic void add(bit rst, logic [3:0] kp, logic rdy, logic clr,
                                logic ev, logic [1:0] ec, logic [3:0] ep,
                                logic [2:0] cnt, logic ov);
        vec_t v;
        v.rst = rst; v.kp = kp; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ec = ec; v.ep = ep; v.cnt = cnt; v.ov = ov;
        vecs.push_back(v);
    endfunction

    initial begin
        // Each row: inputs held for one cycle, outputs expected after that edge.
        //   rst kp       rdy   clr   valid code   pending  count  ovf
        // Single press of key 2, then pop.
        add(0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 3'd0, 1'b0);
        add(0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        // Simultaneous press after a fresh reset: codes 0,1,2,3 back to back.
        add(1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 3'd0, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1110, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1100, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        // Rotation: last grant 1 with keys 0 and 3 pending -> 3 then 0.
        add(0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 3'd0, 1'b0);
        add(0, 4'b1001, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1001, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        // Full FIFO: keys 0,1,2,3,0 with no consumer.
        add(0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 3'd0, 1'b0);
        add(0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 3'd1, 1'b0);
        add(0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0100, 3'd2, 1'b0);
        add(0, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 3'd3, 1'b0);
        add(0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 3'd4, 1'b0);
        add(0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 3'd4, 1'b0);
        // Key 0 again while waiting -> dropped, overflow.
        add(0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 3'd4, 1'b1);
        // Pop from full: no push that cycle, key 0 queued the next.
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0001, 3'd3, 1'b1);
        add(0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd4, 1'b1);
        add(0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 3'd4, 1'b0);
        // Drain with wrapped pointers.
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 3'd3, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 3'd2, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        // Pulse during grant of key 1 -> two code-1 events, no overflow.
        add(0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 3'd0, 1'b0);
        add(0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd2, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        // Set beats clear in the same cycle.
        add(0, 4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0011, 3'd0, 1'b0);
        add(0, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 3'd1, 1'b1);
        add(0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 3'd2, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd1, 1'b0);
        add(0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);

        // Reset state.
        drive(4'b0000, 1'b0, 1'b0);
        reset_n = 1'b0;
        #12;
        check_all("reset", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) tick();

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].kp, vecs[i].rdy, vecs[i].clr);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ep,
                      vecs[i].cnt, vecs[i].ov);
        end

        // Reset mid-operation: three queued (2,3,0), keys 1 and 2 pending.
        drive(4'b1111, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        check_all("pre_rst", 1'b1, 2'd2, 4'b0110, 3'd3, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b1111, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        check_all("post_rst", 1'b1, 2'd0, 4'b1110, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
